// File: rtl/spi_slave_regif_if.sv
// rtl/spi_slave_regif_if.sv - SPI pins and local register bus of the SPI register responder
interface spi_slave_regif_if;
    logic       spi_sclk;
    logic       spi_csn;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       reg_wr_en;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_rd_req;
    logic [7:0] reg_rd_data;
    logic       frame_err;

    modport slave (
        input  spi_sclk, spi_csn, spi_mosi, reg_rd_data,
        output spi_miso, spi_miso_oe, reg_wr_en, reg_addr, reg_wdata, reg_rd_req, frame_err
    );

    modport master (
        output spi_sclk, spi_csn, spi_mosi, reg_rd_data,
        input  spi_miso, spi_miso_oe, reg_wr_en, reg_addr, reg_wdata, reg_rd_req, frame_err
    );
endinterface

// File: rtl/spi_slave_regif.sv
// rtl/spi_slave_regif.sv - SPI mode-0 responder turning 16-bit R/W+addr+data frames into register strobes
module spi_slave_regif #(
    parameter int U_DLY  = 1,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    spi_slave_regif_if.slave  bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CMD   = 3'd1;
    localparam logic [2:0] WDATA = 3'd2;
    localparam logic [2:0] RDATA = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    if (RD_LAT < 1 || RD_LAT > 4 || U_DLY < 0) begin : g_param_out_of_range
    end

    // [0] metastability flop, [1] synchronised value, [2] previous value for edge detect
    logic [2:0] sclk_sync;
    logic [2:0] csn_sync;
    logic [2:0] mosi_sync;

    logic [2:0] state;
    logic [4:0] bit_cnt;
    logic [7:0] shift_in;
    logic [7:0] shift_out;
    logic       over_len;
    logic [2:0] rd_cnt;

    logic       sclk_rise;
    logic       sclk_fall;
    logic       csn_rise;
    logic       csn_fall;
    logic [7:0] shift_next;

    assign sclk_rise  =  sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall  = ~sclk_sync[1] &  sclk_sync[2];
    assign csn_rise   =  csn_sync[1]  & ~csn_sync[2];
    assign csn_fall   = ~csn_sync[1]  &  csn_sync[2];
    assign shift_next = {shift_in[6:0], mosi_sync[2]};

    // CSN flops reset low so a frame already in progress when rst drops never sees a falling edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= 3'b000;
            csn_sync  <= 3'b000;
            mosi_sync <= 3'b000;
        end else begin
            sclk_sync <= {sclk_sync[1:0], bus.spi_sclk};
            csn_sync  <= {csn_sync[1:0],  bus.spi_csn};
            mosi_sync <= {mosi_sync[1:0], bus.spi_mosi};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            bit_cnt         <= 5'd0;
            shift_in        <= 8'd0;
            shift_out       <= 8'd0;
            over_len        <= 1'b0;
            rd_cnt          <= 3'd0;
            bus.spi_miso    <= 1'b0;
            bus.spi_miso_oe <= 1'b0;
            bus.reg_wr_en   <= 1'b0;
            bus.reg_rd_req  <= 1'b0;
            bus.reg_addr    <= 7'd0;
            bus.reg_wdata   <= 8'd0;
            bus.frame_err   <= 1'b0;
        end else begin
            bus.reg_wr_en  <= 1'b0;
            bus.reg_rd_req <= 1'b0;
            bus.frame_err  <= 1'b0;

            // rd_cnt reaches 1 exactly RD_LAT clks after the reg_rd_req cycle
            if (rd_cnt != 3'd0) begin
                rd_cnt <= rd_cnt - 3'd1;
                if (rd_cnt == 3'd1 && state == RDATA) begin
                    shift_out       <= bus.reg_rd_data;
                    bus.spi_miso_oe <= 1'b1;
                end
            end

            if (csn_rise) begin
                state           <= IDLE;
                bit_cnt         <= 5'd0;
                over_len        <= 1'b0;
                rd_cnt          <= 3'd0;
                bus.spi_miso    <= 1'b0;
                bus.spi_miso_oe <= 1'b0;
                bus.frame_err   <= (state == DONE) ? over_len : (state != IDLE);
            end else begin
                case (state)
                    IDLE: begin
                        if (csn_fall) begin
                            state    <= CMD;
                            bit_cnt  <= 5'd0;
                            over_len <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            shift_in <= shift_next;
                            bit_cnt  <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bus.reg_addr <= shift_next[6:0];
                                if (shift_in[6]) begin
                                    state          <= RDATA;
                                    bus.reg_rd_req <= 1'b1;
                                    rd_cnt         <= 3'(RD_LAT + 1);
                                end else begin
                                    state <= WDATA;
                                end
                            end
                        end
                    end
                    WDATA: begin
                        if (sclk_rise) begin
                            shift_in <= shift_next;
                            bit_cnt  <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd15) begin
                                bus.reg_wdata <= shift_next;
                                bus.reg_wr_en <= 1'b1;
                                state         <= DONE;
                            end
                        end
                    end
                    RDATA: begin
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd15)
                                state <= DONE;
                        end else if (sclk_fall) begin
                            bus.spi_miso <= shift_out[7];
                            shift_out    <= {shift_out[6:0], 1'b0};
                        end
                    end
                    DONE: begin
                        if (sclk_rise)
                            over_len <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_regif.sv
// tb/tb_spi_slave_regif.sv - scoreboard bench for spi_slave_regif driving frames as an SPI master
module tb_spi_slave_regif;
    localparam int RD_LAT = 2;

    logic clk;
    logic rst;
    spi_slave_regif_if bus();

    spi_slave_regif #(.U_DLY(1), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_err;
    int          obs_err;
    logic [14:0] exp_wr[$];
    logic [6:0]  exp_rd[$];
    logic [7:0]  rd_val;
    logic [31:0] miso_bits;
    logic        oe_any;
    logic        oe_last;

    // register-file responder: read data appears RD_LAT clks after the strobe
    initial begin
        bus.reg_rd_data = 8'hEE;
        forever begin
            @(negedge clk);
            if (bus.reg_rd_req) begin
                repeat (RD_LAT) @(posedge clk);
                #1 bus.reg_rd_data = rd_val;
            end else if (bus.spi_csn) begin
                bus.reg_rd_data = 8'hEE;
            end
        end
    end

    // scoreboard: pop expected strobes as the DUT produces them
    initial begin
        forever begin
            @(negedge clk);
            if (bus.reg_wr_en || bus.reg_rd_req) begin
                n_vec++;
                if (bus.reg_wr_en && bus.reg_rd_req) begin
                    $display("FAIL strobe_overlap: wr_en and rd_req both high, required never together");
                    n_err++;
                end
            end
            if (bus.reg_wr_en) begin
                n_vec++;
                if (exp_wr.size() == 0) begin
                    $display("FAIL unexpected_write: got addr=%h data=%h, required no write", bus.reg_addr, bus.reg_wdata);
                    n_err++;
                end else begin
                    logic [14:0] e;
                    e = exp_wr.pop_front();
                    if ({bus.reg_addr, bus.reg_wdata} !== e) begin
                        $display("FAIL write_addr_data: got addr=%h data=%h, required addr=%h data=%h",
                                 bus.reg_addr, bus.reg_wdata, e[14:8], e[7:0]);
                        n_err++;
                    end
                end
            end
            if (bus.reg_rd_req) begin
                n_vec++;
                if (exp_rd.size() == 0) begin
                    $display("FAIL unexpected_read: got addr=%h, required no read", bus.reg_addr);
                    n_err++;
                end else begin
                    logic [6:0] e;
                    e = exp_rd.pop_front();
                    if (bus.reg_addr !== e) begin
                        $display("FAIL read_addr: got %h, required %h", bus.reg_addr, e);
                        n_err++;
                    end
                end
            end
            if (bus.frame_err)
                obs_err++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic csn_low(input int half);
        bus.spi_csn = 1'b0;
        wait_clk(half);
    endtask

    task automatic csn_high(input int half);
        wait_clk(half);
        bus.spi_csn = 1'b1;
        wait_clk(4 * half);
    endtask

    task automatic spi_bits(input logic [31:0] bits, input int n, input int half);
        miso_bits = 32'd0;
        oe_any    = 1'b0;
        oe_last   = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.spi_mosi = bits[n-1-i];
            wait_clk(half);
            bus.spi_sclk = 1'b1;
            miso_bits = {miso_bits[30:0], bus.spi_miso};
            oe_any    = oe_any | bus.spi_miso_oe;
            oe_last   = bus.spi_miso_oe;
            wait_clk(half);
            bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_xfer(input logic [31:0] bits, input int n, input int half);
        csn_low(half);
        spi_bits(bits, n, half);
        csn_high(half);
    endtask

    task automatic test_reset;
        n_vec++;
        if ({bus.spi_miso, bus.spi_miso_oe, bus.reg_wr_en, bus.reg_rd_req, bus.reg_addr, bus.reg_wdata, bus.frame_err} !== 20'd0) begin
            $display("FAIL reset_outputs: got miso=%b oe=%b wr=%b rd=%b addr=%h wdata=%h err=%b, required all 0",
                     bus.spi_miso, bus.spi_miso_oe, bus.reg_wr_en, bus.reg_rd_req, bus.reg_addr, bus.reg_wdata, bus.frame_err);
            n_err++;
        end
    endtask

    task automatic test_write;
        int e0;
        e0 = obs_err;
        exp_wr.push_back({7'h12, 8'hA5});
        spi_xfer(32'h12A5, 16, 5);
        n_vec++;
        if (exp_wr.size() != 0) begin
            $display("FAIL write_missing: %0d writes outstanding, required 0", exp_wr.size()); n_err++;
        end
        n_vec++;
        if (oe_any !== 1'b0) begin
            $display("FAIL write_oe: got %b during write, required 0", oe_any); n_err++;
        end
        n_vec++;
        if (obs_err - e0 != 0) begin
            $display("FAIL write_frame_err: got %0d pulses, required 0", obs_err - e0); n_err++;
        end
    endtask

    task automatic test_read;
        int e0;
        e0 = obs_err;
        rd_val = 8'h3C;
        exp_rd.push_back(7'h1A);
        csn_low(8);
        spi_bits(32'h9A00, 16, 8);
        n_vec++;
        if (miso_bits[7:0] !== 8'h3C) begin
            $display("FAIL read_miso: got %h, required 3c", miso_bits[7:0]); n_err++;
        end
        n_vec++;
        if (oe_last !== 1'b1) begin
            $display("FAIL read_oe_high: got %b at bit 16, required 1", oe_last); n_err++;
        end
        csn_high(8);
        n_vec++;
        if ({bus.spi_miso_oe, bus.spi_miso} !== 2'b00) begin
            $display("FAIL read_oe_drop: got oe=%b miso=%b after csn rise, required 0 0", bus.spi_miso_oe, bus.spi_miso); n_err++;
        end
        n_vec++;
        if (exp_rd.size() != 0) begin
            $display("FAIL read_missing: %0d reads outstanding, required 0", exp_rd.size()); n_err++;
        end
        n_vec++;
        if (obs_err - e0 != 0) begin
            $display("FAIL read_frame_err: got %0d pulses, required 0", obs_err - e0); n_err++;
        end
    endtask

    task automatic test_abort;
        int e0;
        e0 = obs_err;
        spi_xfer(32'h05F, 12, 5);
        n_vec++;
        if (obs_err - e0 != 1) begin
            $display("FAIL abort_frame_err: got %0d pulses, required 1", obs_err - e0); n_err++;
        end
        e0 = obs_err;
        exp_wr.push_back({7'h05, 8'h01});
        spi_xfer(32'h0501, 16, 5);
        n_vec++;
        if (exp_wr.size() != 0) begin
            $display("FAIL abort_next_write: %0d writes outstanding, required 0", exp_wr.size()); n_err++;
        end
        n_vec++;
        if (obs_err - e0 != 0) begin
            $display("FAIL abort_next_frame_err: got %0d pulses, required 0", obs_err - e0); n_err++;
        end
    endtask

    task automatic test_overlength;
        int e0;
        e0 = obs_err;
        exp_wr.push_back({7'h07, 8'h33});
        csn_low(5);
        spi_bits({14'd0, 16'h0733, 2'b10}, 18, 5);
        n_vec++;
        if (exp_wr.size() != 0) begin
            $display("FAIL overlen_write: %0d writes outstanding before csn rise, required 0", exp_wr.size()); n_err++;
        end
        n_vec++;
        if (obs_err - e0 != 0) begin
            $display("FAIL overlen_early_err: got %0d pulses before csn rise, required 0", obs_err - e0); n_err++;
        end
        csn_high(5);
        n_vec++;
        if (obs_err - e0 != 1) begin
            $display("FAIL overlen_frame_err: got %0d pulses, required 1", obs_err - e0); n_err++;
        end
    endtask

    task automatic test_back_to_back;
        int e0;
        e0 = obs_err;
        exp_wr.push_back({7'h01, 8'h11});
        exp_wr.push_back({7'h02, 8'h22});
        spi_xfer(32'h0111, 16, 5);
        spi_xfer(32'h0222, 16, 5);
        n_vec++;
        if (exp_wr.size() != 0) begin
            $display("FAIL b2b_writes: %0d writes outstanding, required 0", exp_wr.size()); n_err++;
        end
        n_vec++;
        if (obs_err - e0 != 0) begin
            $display("FAIL b2b_frame_err: got %0d pulses, required 0", obs_err - e0); n_err++;
        end
    endtask

    task automatic test_reset_mid_read;
        int e0;
        e0 = obs_err;
        rd_val = 8'h5A;
        exp_rd.push_back(7'h44);
        csn_low(8);
        spi_bits(32'hC400 >> 6, 10, 8);
        n_vec++;
        if (bus.spi_miso_oe !== 1'b1) begin
            $display("FAIL midread_oe: got %b before rst, required 1", bus.spi_miso_oe); n_err++;
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.spi_miso, bus.spi_miso_oe, bus.reg_wr_en, bus.reg_rd_req, bus.reg_addr, bus.reg_wdata, bus.frame_err} !== 20'd0) begin
            $display("FAIL midread_rst_outputs: got oe=%b addr=%h wdata=%h, required all 0",
                     bus.spi_miso_oe, bus.reg_addr, bus.reg_wdata); n_err++;
        end
        wait_clk(3);
        rst = 1'b0;
        spi_bits(32'h00, 6, 8);
        csn_high(8);
        n_vec++;
        if (obs_err - e0 != 0) begin
            $display("FAIL midread_ignored_err: got %0d pulses, required 0", obs_err - e0); n_err++;
        end
        n_vec++;
        if (exp_rd.size() != 0) begin
            $display("FAIL midread_read: %0d reads outstanding, required 0", exp_rd.size()); n_err++;
        end
        exp_wr.push_back({7'h7F, 8'h80});
        spi_xfer(32'h7F80, 16, 5);
        n_vec++;
        if (exp_wr.size() != 0) begin
            $display("FAIL post_rst_write: %0d writes outstanding, required 0", exp_wr.size()); n_err++;
        end
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        obs_err      = 0;
        rd_val       = 8'h00;
        rst          = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_csn  = 1'b1;
        bus.spi_mosi = 1'b0;
        wait_clk(3);
        test_reset;
        rst = 1'b0;
        wait_clk(5);
        test_write;
        test_read;
        test_abort;
        test_overlength;
        test_back_to_back;
        test_reset_mid_read;
        wait_clk(10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
